// File: rtl/dest_reg_tracker_pkg.sv
// -----------------------------------------------------------------------------
// dest_reg_tracker_pkg
//   Shared pipeline definitions for the destination-register tracker and the
//   fetch-stage hazard detector that consumes its stall.
//
//   Contents:
//     REG_AW        register address width
//     NOP_OPCODE    opcode field of the injected NOP
//     NOP_FUNCT     function field of the injected NOP
//     SLOT_EXE/MEM/WB  slot indices of the in-flight pipeline
//     slot_t        one in-flight record {valid, rd, is_load}
//     SLOT_EMPTY    the all-zero (bubble) record
// -----------------------------------------------------------------------------
package dest_reg_tracker_pkg;

    localparam int unsigned REG_AW = 5;

    // Encoding of the bubble the hazard detector injects while stalled.
    localparam logic [5:0] NOP_OPCODE = 6'h00;
    localparam logic [5:0] NOP_FUNCT  = 6'h15;

    // Slot 0 is the youngest entry (EXE); higher indices are older.
    localparam int unsigned SLOT_EXE = 0;
    localparam int unsigned SLOT_MEM = 1;
    localparam int unsigned SLOT_WB  = 2;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              is_load;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

endpackage : dest_reg_tracker_pkg

// File: rtl/dest_reg_tracker_match.sv
// -----------------------------------------------------------------------------
// reg_match_cmp
//   Compares the two source registers of the instruction in decode against the
//   destination held in a single in-flight slot. Purely combinational; the
//   parent instantiates one per slot and OR-reduces the results.
//
//   Ports:
//     slot_valid  in   slot holds a live register writer
//     slot_rd     in   destination register recorded in the slot
//     rs1, rs2    in   source registers of the decoding instruction
//     rs1_used    in   rs1 is actually read
//     rs2_used    in   rs2 is actually read
//     hit         out  a used source reads the slot's destination
// -----------------------------------------------------------------------------
module reg_match_cmp #(
    parameter int unsigned REG_AW = dest_reg_tracker_pkg::REG_AW
) (
    input  logic              slot_valid,
    input  logic [REG_AW-1:0] slot_rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              rs1_used,
    input  logic              rs2_used,
    output logic              hit
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit = rs1_used && (rs1 == slot_rd);
        rs2_hit = rs2_used && (rs2 == slot_rd);
        // r0 is hard-wired to zero, so a write to it never creates a dependency.
        hit     = slot_valid && (slot_rd != '0) && (rs1_hit || rs2_hit);
    end

endmodule : reg_match_cmp

// File: rtl/dest_reg_tracker.sv
// -----------------------------------------------------------------------------
// dest_reg_tracker
//   Writer-side companion to the fetch-stage hazard detector. Records the
//   destination of every instruction that issues from decode, carries it down
//   an in-flight shift pipeline (slot 0 = EXE, 1 = MEM, 2 = WB), and raises a
//   RAW stall when decode reads a register that is still in flight.
//
//   Parameters:
//     REG_AW      register address width (must match the package slot record)
//     DEPTH       number of in-flight slots tracked, 1..6
//     FORWARDING  0: any in-flight match stalls; 1: only a load in slot 0 stalls
//     CNT_W       width of the saturating stall-cycle counter
//
//   Ports:
//     clk            in   rising-edge clock
//     reset          in   synchronous active-high reset
//     issue_valid    in   decode presents an instruction
//     issue_wr       in   presented instruction writes a register
//     issue_is_load  in   presented instruction is a load
//     issue_rd       in   destination register of the presented instruction
//     rs1, rs2       in   source registers of the presented instruction
//     rs1_used       in   rs1 is actually read
//     rs2_used       in   rs2 is actually read
//     flush          in   kill the presented instruction
//     stall          out  RAW hazard: hold PC/decode, insert a bubble
//     wr_addr        out  per-slot destination, slot 0 in the low field,
//                         zero when the slot is invalid
//     wr_valid       out  per-slot valid bit
//     stall_cycles   out  saturating count of cycles with stall=1
// -----------------------------------------------------------------------------
module dest_reg_tracker #(
    parameter int unsigned REG_AW     = dest_reg_tracker_pkg::REG_AW,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned FORWARDING = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    issue_valid,
    input  logic                    issue_wr,
    input  logic                    issue_is_load,
    input  logic [REG_AW-1:0]       issue_rd,
    input  logic [REG_AW-1:0]       rs1,
    input  logic [REG_AW-1:0]       rs2,
    input  logic                    rs1_used,
    input  logic                    rs2_used,
    input  logic                    flush,
    output logic                    stall,
    output logic [DEPTH*REG_AW-1:0] wr_addr,
    output logic [DEPTH-1:0]        wr_valid,
    output logic [CNT_W-1:0]        stall_cycles
);

    import dest_reg_tracker_pkg::*;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    slot_t            slot_q [DEPTH];
    slot_t            slot_d [DEPTH];
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] stall_cycles_d;

    logic [DEPTH-1:0] match;
    logic             presented;
    logic             accept;

    // -------------------------------------------------------------------------
    // Per-slot source comparison
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        reg_match_cmp #(
            .REG_AW (REG_AW)
        ) u_cmp (
            .slot_valid (slot_q[i].valid),
            .slot_rd    (slot_q[i].rd),
            .rs1        (rs1),
            .rs2        (rs2),
            .rs1_used   (rs1_used),
            .rs2_used   (rs2_used),
            .hit        (match[i])
        );
    end

    // -------------------------------------------------------------------------
    // Stall decision. A flushed instruction is dead, so it neither stalls nor
    // enters the pipeline. The WB slot still counts: the register file is not
    // write-through, so the value is only readable once the entry has retired.
    // -------------------------------------------------------------------------
    always_comb begin
        presented = issue_valid && !flush;
        if (FORWARDING != 0) begin
            // With full forwarding only a load-use in EXE cannot be bypassed.
            stall = presented && match[SLOT_EXE] && slot_q[SLOT_EXE].is_load;
        end else begin
            stall = presented && (|match);
        end
        accept = presented && !stall;
    end

    // -------------------------------------------------------------------------
    // Next-state: shift the in-flight pipeline and count stall cycles
    // -------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default before any conditional
    // update, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_d[i] = SLOT_EMPTY;
        end

        // A stalled, flushed or non-writing instruction leaves a bubble in
        // slot 0; the older entries keep draining, so a stall always clears
        // within DEPTH cycles.
        if (accept && issue_wr && (issue_rd != '0)) begin
            slot_d[SLOT_EXE].valid   = 1'b1;
            slot_d[SLOT_EXE].rd      = issue_rd;
            slot_d[SLOT_EXE].is_load = issue_is_load;
        end

        for (int i = 1; i < DEPTH; i++) begin
            slot_d[i] = slot_q[i-1];
        end

        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the slot array is a handful of flops, not a RAM, and must
            // come out of reset empty or a stale entry would raise a stall.
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= SLOT_EMPTY;
            end
            stall_cycles_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        wr_addr  = '0;
        wr_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_valid[i]                  = slot_q[i].valid;
            wr_addr[i*REG_AW +: REG_AW]  = slot_q[i].valid ? slot_q[i].rd : '0;
        end
        stall_cycles = stall_cycles_q;
    end

endmodule : dest_reg_tracker
